// File: rtl/a10_sata_xcvr_rstctl_pkg.sv
// Shared types for the Arria 10 SATA transceiver reset sequencer.
// State encodings and counter sizing helper.
package a10_sata_xcvr_rstctl_pkg;

  typedef enum logic [1:0] {
    TX_RESET    = 2'd0,
    TX_WAIT_CAL = 2'd1,
    TX_DIG_WAIT = 2'd2,
    TX_READY    = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_RESET    = 2'd0,
    RX_WAIT_CAL = 2'd1,
    RX_WAIT_LTD = 2'd2,
    RX_READY    = 2'd3
  } rx_state_t;

  // Bit positions of the status bundle fed through the synchronizer
  localparam int SB_PLL_LOCKED = 4;
  localparam int SB_PLL_CAL    = 3;
  localparam int SB_TX_CAL     = 2;
  localparam int SB_RX_CAL     = 1;
  localparam int SB_LTD        = 0;
  localparam int SB_W          = 5;

  // Width able to hold the largest delay, with one spare bit
  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/a10_sata_xcvr_reset_ctrl_status_sync.sv
// Two-flop synchronizer for the asynchronous transceiver status bits.
// Clears to zero under the synchronous reset.
module a10_sata_xcvr_status_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Double-register each bit into the clk domain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/a10_sata_xcvr_reset_ctrl.sv
// Reset sequencer for the Arria 10 SATA transceiver channel.
// Independent TX and RX FSMs; outputs registered from next state.
module a10_sata_xcvr_reset_ctrl
  import a10_sata_xcvr_rstctl_pkg::*;
#(
  parameter int ANALOG_RESET_CYCLES     = 100,
  parameter int TX_DIGITAL_DELAY_CYCLES = 100,
  parameter int LTD_STABLE_CYCLES       = 500
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tx_reset_req,
  input  logic rx_reset_req,
  input  logic pll_locked,
  input  logic pll_cal_busy,
  input  logic tx_cal_busy,
  input  logic rx_cal_busy,
  input  logic rx_is_lockedtodata,
  output logic tx_analogreset,
  output logic tx_digitalreset,
  output logic rx_analogreset,
  output logic rx_digitalreset,
  output logic tx_ready,
  output logic rx_ready
);

  localparam int CW = cnt_width(ANALOG_RESET_CYCLES,
                                TX_DIGITAL_DELAY_CYCLES,
                                LTD_STABLE_CYCLES);

  // Counter value seen on the last cycle of each timed wait
  localparam logic [CW-1:0] AN_LAST  = CW'(ANALOG_RESET_CYCLES - 1);
  localparam logic [CW-1:0] DIG_LAST = CW'(TX_DIGITAL_DELAY_CYCLES - 1);
  localparam logic [CW-1:0] LTD_LAST = CW'(LTD_STABLE_CYCLES - 1);

  logic [SB_W-1:0] w_sync;
  logic            w_pll_locked;
  logic            w_pll_cal_busy;
  logic            w_tx_cal_busy;
  logic            w_rx_cal_busy;
  logic            w_ltd;
  logic            w_tx_lost;

  tx_state_t       r_tx_st;
  tx_state_t       w_tx_nxt;
  logic [CW-1:0]   r_tx_cnt;
  logic [CW-1:0]   w_tx_cnt;
  logic            r_tx_ana;
  logic            r_tx_dig;
  logic            r_tx_rdy;

  rx_state_t       r_rx_st;
  rx_state_t       w_rx_nxt;
  logic [CW-1:0]   r_rx_cnt;
  logic [CW-1:0]   w_rx_cnt;
  logic            r_rx_ana;
  logic            r_rx_dig;
  logic            r_rx_rdy;

  a10_sata_xcvr_status_sync #(
    .W (SB_W)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_d     ({pll_locked, pll_cal_busy, tx_cal_busy,
               rx_cal_busy, rx_is_lockedtodata}),
    .o_q     (w_sync)
  );

  assign w_pll_locked   = w_sync[SB_PLL_LOCKED];
  assign w_pll_cal_busy = w_sync[SB_PLL_CAL];
  assign w_tx_cal_busy  = w_sync[SB_TX_CAL];
  assign w_rx_cal_busy  = w_sync[SB_RX_CAL];
  assign w_ltd          = w_sync[SB_LTD];
  assign w_tx_lost      = !w_pll_locked || w_tx_cal_busy;

  // TX next-state: request, then lock/cal loss, then progress
  always_comb begin
    w_tx_nxt = r_tx_st;
    if (tx_reset_req) begin
      w_tx_nxt = TX_RESET;
    end else begin
      unique case (r_tx_st)
        TX_RESET: begin
          if (r_tx_cnt == AN_LAST) w_tx_nxt = TX_WAIT_CAL;
        end
        TX_WAIT_CAL: begin
          if (w_pll_locked && !w_pll_cal_busy && !w_tx_cal_busy)
            w_tx_nxt = TX_DIG_WAIT;
        end
        TX_DIG_WAIT: begin
          if (w_tx_lost) w_tx_nxt = TX_RESET;
          else if (r_tx_cnt == DIG_LAST) w_tx_nxt = TX_READY;
        end
        TX_READY: begin
          if (w_tx_lost) w_tx_nxt = TX_RESET;
        end
        default: w_tx_nxt = TX_RESET;
      endcase
    end
  end

  // TX counter: clears on any state entry, otherwise saturates
  always_comb begin
    w_tx_cnt = r_tx_cnt;
    if (tx_reset_req || (w_tx_nxt != r_tx_st)) w_tx_cnt = '0;
    else if (r_tx_cnt != '1) w_tx_cnt = r_tx_cnt + 1'b1;
  end

  // RX next-state: request, then cal busy, then lock loss, then progress
  always_comb begin
    w_rx_nxt = r_rx_st;
    if (rx_reset_req) begin
      w_rx_nxt = RX_RESET;
    end else begin
      unique case (r_rx_st)
        RX_RESET: begin
          if (r_rx_cnt == AN_LAST) w_rx_nxt = RX_WAIT_CAL;
        end
        RX_WAIT_CAL: begin
          if (!w_rx_cal_busy) w_rx_nxt = RX_WAIT_LTD;
        end
        RX_WAIT_LTD: begin
          if (w_rx_cal_busy) w_rx_nxt = RX_WAIT_CAL;
          else if (w_ltd && (r_rx_cnt == LTD_LAST)) w_rx_nxt = RX_READY;
        end
        RX_READY: begin
          if (w_rx_cal_busy) w_rx_nxt = RX_WAIT_CAL;
          else if (!w_ltd) w_rx_nxt = RX_WAIT_LTD;
        end
        default: w_rx_nxt = RX_RESET;
      endcase
    end
  end

  // RX counter: also restarts whenever lock-to-data drops while waiting
  always_comb begin
    w_rx_cnt = r_rx_cnt;
    if (rx_reset_req || (w_rx_nxt != r_rx_st)) w_rx_cnt = '0;
    else if ((r_rx_st == RX_WAIT_LTD) && !w_ltd) w_rx_cnt = '0;
    else if (r_rx_cnt != '1) w_rx_cnt = r_rx_cnt + 1'b1;
  end

  // TX state, counter and next-state-decoded outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_tx_st  <= TX_RESET;
      r_tx_cnt <= '0;
      r_tx_ana <= 1'b1;
      r_tx_dig <= 1'b1;
      r_tx_rdy <= 1'b0;
    end else begin
      r_tx_st  <= w_tx_nxt;
      r_tx_cnt <= w_tx_cnt;
      r_tx_ana <= (w_tx_nxt == TX_RESET) || (w_tx_nxt == TX_WAIT_CAL);
      r_tx_dig <= (w_tx_nxt != TX_READY);
      r_tx_rdy <= (w_tx_nxt == TX_READY);
    end
  end

  // RX state, counter and next-state-decoded outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rx_st  <= RX_RESET;
      r_rx_cnt <= '0;
      r_rx_ana <= 1'b1;
      r_rx_dig <= 1'b1;
      r_rx_rdy <= 1'b0;
    end else begin
      r_rx_st  <= w_rx_nxt;
      r_rx_cnt <= w_rx_cnt;
      r_rx_ana <= (w_rx_nxt == RX_RESET) || (w_rx_nxt == RX_WAIT_CAL);
      r_rx_dig <= (w_rx_nxt != RX_READY);
      r_rx_rdy <= (w_rx_nxt == RX_READY);
    end
  end

  assign tx_analogreset  = r_tx_ana;
  assign tx_digitalreset = r_tx_dig;
  assign tx_ready        = r_tx_rdy;
  assign rx_analogreset  = r_rx_ana;
  assign rx_digitalreset = r_rx_dig;
  assign rx_ready        = r_rx_rdy;

endmodule

// File: tb/tb_a10_sata_xcvr_reset_ctrl.sv
// Bench for the SATA transceiver reset sequencer.
// Vector table, directed corner sequences, random run vs model.
module tb_a10_sata_xcvr_reset_ctrl;

  localparam int A = 4;
  localparam int D = 3;
  localparam int L = 8;

  // status order: {pll_locked, pll_cal_busy, tx_cal_busy, rx_cal_busy, ltd}
  localparam logic [4:0] GOOD = 5'b10001;
  // output order: {tx_ana, tx_dig, rx_ana, rx_dig, tx_ready, rx_ready}
  localparam logic [5:0] ALL_RST = 6'b111100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       tx_reset_req = 1'b0;
  logic       rx_reset_req = 1'b0;
  logic [4:0] st = GOOD;

  logic tx_analogreset, tx_digitalreset;
  logic rx_analogreset, rx_digitalreset;
  logic tx_ready, rx_ready;
  logic [5:0] dut_o;

  assign dut_o = {tx_analogreset, tx_digitalreset,
                  rx_analogreset, rx_digitalreset,
                  tx_ready, rx_ready};

  a10_sata_xcvr_reset_ctrl #(
    .ANALOG_RESET_CYCLES     (A),
    .TX_DIGITAL_DELAY_CYCLES (D),
    .LTD_STABLE_CYCLES       (L)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .tx_reset_req       (tx_reset_req),
    .rx_reset_req       (rx_reset_req),
    .pll_locked         (st[4]),
    .pll_cal_busy       (st[3]),
    .tx_cal_busy        (st[2]),
    .rx_cal_busy        (st[1]),
    .rx_is_lockedtodata (st[0]),
    .tx_analogreset     (tx_analogreset),
    .tx_digitalreset    (tx_digitalreset),
    .rx_analogreset     (rx_analogreset),
    .rx_digitalreset    (rx_digitalreset),
    .tx_ready           (tx_ready),
    .rx_ready           (rx_ready)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                  nm, act, act, exp, exp);
  endtask

  // Reference model: phase 0 reset, 1 wait cal, 2 wait digital/ltd,
  // 3 ready; cnt is cycles elapsed in the phase (or ltd streak).
  logic [4:0] syncq[$];
  int tph = 0, tcnt = 0, rph = 0, rcnt = 0;

  task automatic model_step(input logic rn, input logic tq,
                            input logic rq, input logic [4:0] raw);
    logic [4:0] s;
    logic lock, pcal, tcal, rcal, ltd;
    if (!rn) begin
      syncq = '{5'd0, 5'd0};
      tph = 0; tcnt = 0; rph = 0; rcnt = 0;
      return;
    end
    s = syncq.pop_front();
    syncq.push_back(raw);
    lock = s[4]; pcal = s[3]; tcal = s[2]; rcal = s[1]; ltd = s[0];
    if (tq) begin
      tph = 0; tcnt = 0;
    end else if (tph == 0) begin
      tcnt++;
      if (tcnt >= A) begin tph = 1; tcnt = 0; end
    end else if (tph == 1) begin
      if (lock && !pcal && !tcal) begin tph = 2; tcnt = 0; end
    end else if (!lock || tcal) begin
      tph = 0; tcnt = 0;
    end else if (tph == 2) begin
      tcnt++;
      if (tcnt >= D) begin tph = 3; tcnt = 0; end
    end
    if (rq) begin
      rph = 0; rcnt = 0;
    end else if (rph == 0) begin
      rcnt++;
      if (rcnt >= A) begin rph = 1; rcnt = 0; end
    end else if (rph == 1) begin
      if (!rcal) begin rph = 2; rcnt = 0; end
    end else if (rcal) begin
      rph = 1; rcnt = 0;
    end else if (!ltd) begin
      rph = 2; rcnt = 0;
    end else if (rph == 2) begin
      rcnt++;
      if (rcnt >= L) begin rph = 3; rcnt = 0; end
    end
  endtask

  function automatic logic [5:0] model_o();
    return {tph < 2, tph < 3, rph < 2, rph < 3, tph == 3, rph == 3};
  endfunction

  // Drive one cycle of inputs, clock it, advance the model
  task automatic tick(input logic rn, input logic tq,
                      input logic rq, input logic [4:0] s);
    reset_n = rn;
    tx_reset_req = tq;
    rx_reset_req = rq;
    st = s;
    @(posedge clk);
    model_step(rn, tq, rq, s);
    #1;
  endtask

  task automatic step(input string nm, input logic rn, input logic tq,
                      input logic rq, input logic [4:0] s);
    tick(rn, tq, rq, s);
    check(nm, dut_o, model_o());
  endtask

  typedef struct {
    logic       rn;
    logic       tq;
    logic       rq;
    logic [4:0] s;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rn, input logic [4:0] s,
                     input logic [5:0] exp, input int n);
    vec_t v;
    v.rn = rn; v.tq = 1'b0; v.rq = 1'b0; v.s = s; v.exp = exp;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  initial begin
    int f_txa, f_txr, f_rxa, f_rxd, f_rxr, rx_lows;
    logic [4:0] s;
    logic [4:0] g;
    logic ltd;

    // Power-up with good status, then an rx lock-to-data drop
    add(1'b0, GOOD,     ALL_RST,   2);
    add(1'b1, GOOD,     ALL_RST,   4);
    add(1'b1, GOOD,     6'b010100, 3);
    add(1'b1, GOOD,     6'b000110, 5);
    add(1'b1, GOOD,     6'b000011, 2);
    add(1'b1, 5'b10000, 6'b000011, 2);
    add(1'b1, 5'b10000, 6'b000110, 1);
    add(1'b1, GOOD,     6'b000110, 1);
    foreach (tbl[i]) begin
      tick(tbl[i].rn, tbl[i].tq, tbl[i].rq, tbl[i].s);
      check($sformatf("tbl[%0d]", i), dut_o, tbl[i].exp);
    end

    // Cal hold-off: tx_cal_busy high for 50 cycles after reset
    step("calhold_rst", 1'b0, 1'b0, 1'b0, 5'b10101);
    step("calhold_rst", 1'b0, 1'b0, 1'b0, 5'b10101);
    f_txa = -1; f_rxr = -1;
    for (int i = 0; i < 80; i++) begin
      step("calhold", 1'b1, 1'b0, 1'b0, (i < 50) ? 5'b10101 : GOOD);
      if (f_txa < 0 && !tx_analogreset) f_txa = i;
      if (f_rxr < 0 && rx_ready) f_rxr = i;
    end
    check("calhold_tx_ana_fall", f_txa, 52);
    check("calhold_rx_ready", f_rxr, 12);

    // LTD glitch: high 5, low 1, then high again
    f_rxa = -1; f_rxd = -1;
    for (int i = 0; i < 40; i++) begin
      ltd = ((i >= 10) && (i < 15)) || (i >= 16);
      step("glitch", 1'b1, 1'b0, i == 0, {4'b1000, ltd});
      if (f_rxa < 0 && !rx_analogreset) f_rxa = i;
      if (f_rxd < 0 && !rx_digitalreset) f_rxd = i;
    end
    check("glitch_rx_ana_fall", f_rxa, 5);
    check("glitch_rx_dig_fall", f_rxd, 25);

    // PLL lock loss while TX ready
    f_txr = -1; rx_lows = 0;
    for (int i = 0; i < 30; i++) begin
      step("pll_loss", 1'b1, 1'b0, 1'b0, (i < 4) ? 5'b00001 : GOOD);
      if (i == 2)
        check("pll_loss_tx_out",
              {tx_analogreset, tx_digitalreset, tx_ready}, 3'b110);
      if (i > 2 && f_txr < 0 && tx_ready) f_txr = i;
      if (!rx_ready) rx_lows++;
    end
    check("pll_loss_tx_ready_again", f_txr, 10);
    check("pll_loss_rx_unaffected", rx_lows, 0);

    // Simultaneous requests, plus a second rx request mid-reset
    f_txa = -1; f_txr = -1; f_rxa = -1; f_rxr = -1;
    for (int i = 0; i < 30; i++) begin
      step("req", 1'b1, i == 0, (i == 0) || (i == 2), GOOD);
      if (i == 0) check("req_all_reset", dut_o, ALL_RST);
      if (f_txa < 0 && !tx_analogreset) f_txa = i;
      if (f_txr < 0 && tx_ready) f_txr = i;
      if (f_rxa < 0 && !rx_analogreset) f_rxa = i;
      if (f_rxr < 0 && rx_ready) f_rxr = i;
    end
    check("req_tx_ana_fall", f_txa, 5);
    check("req_tx_ready", f_txr, 8);
    check("req_rx_ana_fall", f_rxa, 7);
    check("req_rx_ready", f_rxr, 15);

    // reset_n asserted while RX waits for lock-to-data
    for (int i = 0; i < 6; i++)
      step("midrst_pre", 1'b1, 1'b0, i == 0, 5'b10000);
    check("midrst_in_ltd_wait", {rx_analogreset, rx_digitalreset}, 2'b01);
    tick(1'b0, 1'b0, 1'b0, 5'b10000);
    check("midrst_all_reset", dut_o, ALL_RST);
    f_txa = -1; f_rxd = -1;
    for (int i = 0; i < 20; i++) begin
      step("midrst_post", 1'b1, 1'b0, 1'b0, GOOD);
      if (f_txa < 0 && !tx_analogreset) f_txa = i;
      if (f_rxd < 0 && !rx_digitalreset) f_rxd = i;
    end
    check("midrst_tx_ana_fall", f_txa, 4);
    check("midrst_rx_dig_fall", f_rxd, 12);

    // Random status wander, requests and resets against the model
    s = GOOD;
    g = GOOD;
    for (int n = 0; n < 2500; n++) begin
      for (int b = 0; b < 5; b++) begin
        if ($urandom_range(99) < 3) s[b] = ~s[b];
        else if (s[b] != g[b] && $urandom_range(99) < 15) s[b] = g[b];
      end
      step("rand",
           $urandom_range(199) != 0,
           $urandom_range(59) == 0,
           $urandom_range(59) == 0,
           s);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/a10_sata_xcvr_reset_ctrl.md
Name: a10_sata_xcvr_reset_ctrl

Overview:
Reset sequencer for the Arria 10 SATA transceiver channel (a10_sata_xcvr_core).
- Drives tx/rx analog and digital resets in the order the transceiver requires: calibration done, then PLL/CDR lock, then digital release.
- Runs independent TX and RX state machines, and re-sequences on lock loss, recalibration or a link-layer reset request.
- Sits between the SATA link/OOB logic and the transceiver core, in the reconfig/management clock domain.

Parameters:
- ANALOG_RESET_CYCLES, 100, minimum clk cycles that tx/rx_analogreset is held asserted after entry to a reset state.
- TX_DIGITAL_DELAY_CYCLES, 100, clk cycles between tx_analogreset release and tx_digitalreset release.
- LTD_STABLE_CYCLES, 500, consecutive clk cycles rx_is_lockedtodata must stay high before rx_digitalreset is released.
- Counter width: $clog2 of the largest parameter, plus 1.

Ports:
- clk  in  1  management clock (same as reconfig_clk).
- reset_n  in  1  synchronous active-low reset.
- tx_reset_req  in  1  single-cycle request to re-run the TX sequence.
- rx_reset_req  in  1  single-cycle request to re-run the RX sequence.
- pll_locked  in  1  TX serial PLL lock (async).
- pll_cal_busy  in  1  TX PLL calibration busy (async).
- tx_cal_busy  in  1  channel TX calibration busy (async).
- rx_cal_busy  in  1  channel RX calibration busy (async).
- rx_is_lockedtodata  in  1  CDR locked to data (async).
- tx_analogreset  out  1  to transceiver.
- tx_digitalreset  out  1  to transceiver.
- rx_analogreset  out  1  to transceiver.
- rx_digitalreset  out  1  to transceiver.
- tx_ready  out  1  TX datapath usable.
- rx_ready  out  1  RX datapath usable.

Behaviour:
- One clock. Reset is synchronous and active-low. While reset_n=0: all four xcvr resets=1, tx_ready=0, rx_ready=0, both FSMs in *_RESET, counters=0.
- All five async status inputs pass through a 2-flop synchronizer, giving 2 cycles of latency. Unless stated otherwise, the conditions below refer to the synchronized values.
- All outputs are registered and decoded from the next state, so an output changes on the same edge as the state change.
- Counters clear on every state entry. A "wait N" condition is met on the Nth cycle in the state.

TX FSM:
- TX_RESET: analog=1, digital=1. After ANALOG_RESET_CYCLES, go to TX_WAIT_CAL.
- TX_WAIT_CAL: analog=1, digital=1. When pll_locked=1, pll_cal_busy=0 and tx_cal_busy=0, go to TX_DIG_WAIT.
- TX_DIG_WAIT: analog=0, digital=1. After TX_DIGITAL_DELAY_CYCLES, go to TX_READY.
- TX_READY: analog=0, digital=0, tx_ready=1.
- From TX_DIG_WAIT or TX_READY: pll_locked=0 or tx_cal_busy=1 returns to TX_RESET.
- tx_reset_req in any state goes to TX_RESET. Priority: reset_n > tx_reset_req > lock/cal loss > normal progress.

RX FSM:
- RX_RESET: analog=1, digital=1. After ANALOG_RESET_CYCLES, go to RX_WAIT_CAL.
- RX_WAIT_CAL: analog=1, digital=1. When rx_cal_busy=0, go to RX_WAIT_LTD.
- RX_WAIT_LTD: analog=0, digital=1. Counter increments while rx_is_lockedtodata=1 and clears when it is 0. At count LTD_STABLE_CYCLES, go to RX_READY.
- RX_READY: analog=0, digital=0, rx_ready=1.
- RX_READY with rx_is_lockedtodata=0: go to RX_WAIT_LTD. rx_digitalreset reasserts, analog stays released, counter restarts.
- rx_cal_busy=1 in RX_WAIT_LTD or RX_READY returns to RX_WAIT_CAL (reconfiguration-driven recalibration).
- rx_reset_req in any state goes to RX_RESET. Priority: reset_n > rx_reset_req > cal_busy > lock loss > normal progress.

General rules:
- TX and RX FSMs are fully independent; simultaneous requests are each served.
- A request arriving while already in *_RESET restarts that state's counter.
- Counters saturate and never wrap.

Decomposition:
- Package a10_sata_xcvr_rstctl_pkg: TX state enum (TX_RESET, TX_WAIT_CAL, TX_DIG_WAIT, TX_READY), RX state enum (RX_RESET, RX_WAIT_CAL, RX_WAIT_LTD, RX_READY), and a function computing counter width.
- Sub-module a10_sata_xcvr_status_sync: parameterized-width 2-flop synchronizer, instantiated once for the 5 status bits and reset to 0 (pll_locked=0 and rx_is_lockedtodata=0; cal_busy bits also reset to 0, which is safe because the FSMs have not yet left *_RESET).

Test Plan:
All scenarios use ANALOG_RESET_CYCLES=4, TX_DIGITAL_DELAY_CYCLES=3, LTD_STABLE_CYCLES=8.
- Power-up: release reset_n with all status inputs good and steady. Required: tx_analogreset falls 4+ cycles after release and after sync latency; tx_digitalreset falls exactly 3 cycles later; tx_ready=1 on that same edge. RX releases digital exactly 8 cycles after rx_analogreset falls.
- Cal hold-off: tx_cal_busy=1 for 50 cycles after reset. Required: tx_analogreset stays 1 until 2 cycles after tx_cal_busy falls; RX is unaffected.
- LTD glitch: rx_is_lockedtodata high 5 cycles, low 1, then high. Required: rx_digitalreset released 8 cycles after the second rise (plus sync latency), not earlier.
- Lock loss: drop rx_is_lockedtodata in RX_READY. Required: rx_ready=0 and rx_digitalreset=1 within 3 cycles, rx_analogreset stays 0; drop pll_locked in TX_READY. Required: all TX resets=1 and tx_ready=0 within 3 cycles.
- Requests: pulse tx_reset_req and rx_reset_req on the same cycle while both are ready. Required: both FSMs re-sequence fully. A second rx_reset_req mid-RX_RESET extends analog hold to 4 cycles after the second pulse.
- Reset mid-sequence: assert reset_n=0 during RX_WAIT_LTD. Required: next edge gives all resets=1 and ready=0, and the sequence restarts from *_RESET.
